// File: rtl/darkrom_arbiter.sv
// Arbitrates the single-port firmware ROM between instruction fetch (I) and constant loads (D).
// Define DARKROM_ARB_RR_EN for round-robin arbitration instead of fixed I > D with starvation guard.
module darkrom_arbiter #(
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [63:0] DEPTH_W   = 64'(DEPTH);

  logic        pend_i;
  logic        pend_d;
  logic        pend_err;
  logic [31:0] sel_addr;
  logic [63:0] sel_word;
  logic        sel_err;
  logic        any_gnt;

`ifdef DARKROM_ARB_RR_EN
  logic        rr_ptr;   // 0: I preferred on contention, 1: D preferred
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0]  starve_cnt;
`endif

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
`ifdef DARKROM_ARB_RR_EN
    if (i_req && d_req) begin
      if (rr_ptr) d_gnt = 1'b1;
      else        i_gnt = 1'b1;
    end else begin
      i_gnt = i_req;
      d_gnt = d_req;
    end
`else
    if (d_req && (!i_req || starve_cnt == STARVE_MAX)) d_gnt = 1'b1;
    else                                              i_gnt = i_req;
`endif
    // Reset forces every output low, including the combinational grant path.
    if (XRES) begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
    end
  end

  // Full-width word index keeps huge addresses from aliasing back into range.
  assign any_gnt  = i_gnt | d_gnt;
  assign sel_addr = d_gnt ? d_addr : i_addr;
  assign sel_word = {34'd0, sel_addr[31:2]};
  assign sel_err  = (sel_addr[1:0] != 2'b00) || (sel_word >= DEPTH_W);
  assign rom_en   = any_gnt && !sel_err;
  assign rom_addr = rom_en ? sel_addr : 32'd0;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      pend_i   <= 1'b0;
      pend_d   <= 1'b0;
      pend_err <= 1'b0;
    end else begin
      pend_i   <= i_gnt;
      pend_d   <= d_gnt;
      pend_err <= any_gnt && sel_err;
    end
  end

`ifdef DARKROM_ARB_RR_EN
  always_ff @(posedge XCLK) begin
    if (XRES)       rr_ptr <= 1'b0;
    else if (i_gnt) rr_ptr <= 1'b1;
    else if (d_gnt) rr_ptr <= 1'b0;
  end
`else
  always_ff @(posedge XCLK) begin
    if (XRES)
      starve_cnt <= 4'd0;
    else if (d_req && !d_gnt)
      starve_cnt <= (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 4'd1;
    else
      starve_cnt <= 4'd0;
  end
`endif

  assign i_rvalid = pend_i && !XRES;
  assign d_rvalid = pend_d && !XRES;
  assign i_err    = i_rvalid && pend_err;
  assign d_err    = d_rvalid && pend_err;
  assign i_rdata  = !i_rvalid ? 32'd0 : (pend_err ? NOP : rom_data);
  assign d_rdata  = !d_rvalid ? 32'd0 : (pend_err ? NOP : rom_data);

endmodule

// File: tb/tb_darkrom_arbiter.sv
// Self-checking bench for darkrom_arbiter: directed scenarios then random traffic against a reference model.
module tb_darkrom_arbiter;

  localparam int          DEPTH = 512;
  localparam int          LIMIT = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        XCLK = 1'b0;
  logic        XRES;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  logic [31:0] rom_mem [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  // Reference-model state: who owns the response due next cycle, and arbitration history.
  int          pend_owner;   // 0 none, 1 I, 2 D
  logic        pend_bad;
  logic [31:0] pend_addr;
  int          d_wait;       // consecutive cycles D asked and was refused
  int          last_gnt;     // 0 I, 1 D

  always #5 XCLK = ~XCLK;

  darkrom_arbiter dut (
    .XCLK     (XCLK),
    .XRES     (XRES),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .i_err    (i_err),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  // Registered-read ROM that returns NOP when not enabled.
  always @(posedge XCLK) rom_data <= rom_en ? rom_mem[rom_addr[10:2]] : NOP;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    longint unsigned word;
    word = longint'(a) / 4;
    return (a % 4 != 0) || (word >= DEPTH);
  endfunction

  task automatic step(input logic xr, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [31:0] da);
    logic        eg_i, eg_d, gb, ri, rd;
    logic [31:0] ga, resp;
    @(negedge XCLK);
    XRES = xr; i_req = ir; i_addr = ia; d_req = dr; d_addr = da;
    #1;
    eg_i = 1'b0;
    eg_d = 1'b0;
    if (!xr) begin
      if (ir && dr) begin
`ifdef DARKROM_ARB_RR_EN
        if (last_gnt == 0) eg_d = 1'b1; else eg_i = 1'b1;
`else
        if (d_wait >= LIMIT) eg_d = 1'b1; else eg_i = 1'b1;
`endif
      end else begin
        eg_i = ir;
        eg_d = dr;
      end
    end
    ga = eg_d ? da : ia;
    gb = bad_addr(ga);
    check("i_gnt",    32'(i_gnt),  32'(eg_i));
    check("d_gnt",    32'(d_gnt),  32'(eg_d));
    check("rom_en",   32'(rom_en), 32'((eg_i || eg_d) && !gb));
    check("rom_addr", rom_addr,    ((eg_i || eg_d) && !gb) ? ga : 32'd0);

    ri   = !xr && pend_owner == 1;
    rd   = !xr && pend_owner == 2;
    resp = pend_bad ? NOP : rom_mem[pend_addr[10:2]];
    check("i_rvalid", 32'(i_rvalid), 32'(ri));
    check("i_rdata",  i_rdata,       ri ? resp : 32'd0);
    check("i_err",    32'(i_err),    32'(ri && pend_bad));
    check("d_rvalid", 32'(d_rvalid), 32'(rd));
    check("d_rdata",  d_rdata,       rd ? resp : 32'd0);
    check("d_err",    32'(d_err),    32'(rd && pend_bad));

    if (xr) begin
      pend_owner = 0;
      pend_bad   = 1'b0;
      d_wait     = 0;
      last_gnt   = 1;
    end else begin
      pend_owner = eg_i ? 1 : (eg_d ? 2 : 0);
      pend_bad   = gb;
      pend_addr  = ga;
      if (eg_i)      last_gnt = 0;
      else if (eg_d) last_gnt = 1;
      d_wait = (dr && !eg_d) ? ((d_wait + 1 > LIMIT) ? LIMIT : d_wait + 1) : 0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      return {21'd0, 9'($urandom_range(0, DEPTH-1)), 2'($urandom_range(1, 3))};
    else if (r == 1) return {$urandom_range(DEPTH, 32'h3FFF_FFFF), 2'b00};
    else             return {21'd0, 9'($urandom_range(0, DEPTH-1)), 2'b00};
  endfunction

  initial begin
    logic        ir, dr, xr;
    logic [31:0] ia, da;
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = $urandom;
    pend_owner = 0; pend_bad = 1'b0; pend_addr = 32'd0; d_wait = 0; last_gnt = 1;
    XRES = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = 32'd0; d_addr = 32'd0;

    // Outputs held low during reset even with requests pending.
    step(1, 1, 32'h4, 1, 32'h8);
    step(1, 0, 32'h0, 0, 32'h0);

    // Single I read of word 2, response next cycle.
    step(0, 1, 32'h8, 0, 32'h0);
    step(0, 0, 32'h0, 0, 32'h0);

    // D misaligned, then D one word past the end.
    step(0, 0, 32'h0, 1, 32'h802);
    step(0, 0, 32'h0, 1, 32'h800);
    step(0, 0, 32'h0, 0, 32'h0);

    // Contention: fixed priority gives I four grants then D; round-robin alternates.
    for (int k = 0; k < 10; k++) step(0, 1, 32'h10, 1, 32'h20);
    step(0, 0, 32'h0, 0, 32'h0);

    // Back-to-back I reads of words 0..2.
    step(0, 1, 32'h0, 0, 32'h0);
    step(0, 1, 32'h4, 0, 32'h0);
    step(0, 1, 32'h8, 0, 32'h0);
    step(0, 0, 32'h0, 0, 32'h0);

    // Reset right after a grant drops the pending response.
    step(0, 1, 32'hC, 0, 32'h0);
    step(1, 0, 32'h0, 0, 32'h0);
    step(0, 0, 32'h0, 0, 32'h0);

    // Random traffic; a requester keeps its address until granted.
    ir = 1'b0; dr = 1'b0; ia = 32'd0; da = 32'd0;
    for (int n = 0; n < 400; n++) begin
      if (!(ir && pend_owner != 1) || $urandom_range(0, 15) == 0) begin
        ir = 1'($urandom_range(0, 1));
        ia = rand_addr();
      end
      if (!(dr && pend_owner != 2) || $urandom_range(0, 15) == 0) begin
        dr = 1'($urandom_range(0, 2) != 0);
        da = rand_addr();
      end
      xr = ($urandom_range(0, 59) == 0);
      step(xr, ir, ia, dr, da);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
